priority_encoder_q: RTL and testbench

//  - Parametrised N-to-log2(N) request encoder with sticky pending register and valid/ready output.
//  - Turns sporadic, possibly multi-hot request strobes into a serial stream of encoded indices.
//  - Nothing is dropped: every request is held until its index is handed off downstream.
//  - Used where producers raise event lines and one consumer services them one index at a time.
//  - Arbitration is fixed priority (LSB first) or round-robin, selectable at runtime.

---
 rtl/priority_encoder_q_if.sv | 18 +
 rtl/priority_encoder_q.sv | 131 +++++++++++++
 tb/tb_priority_encoder_q.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/priority_encoder_q_if.sv
// priority_encoder_q_if
//   Downstream valid/ready channel carrying one encoded request index per beat.
//   Parameter W is the index width; it must equal $clog2(N) of the attached encoder.
//   Signals:
//     out_valid  encoder -> consumer  out_idx holds a granted index
//     out_ready  consumer -> encoder  consumer accepts out_idx this cycle
//     out_idx    encoder -> consumer  granted index, W bits
//   Modports: master (encoder side), slave (consumer side).
interface priority_encoder_q_if #(
    parameter int W = 3
) ();
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;

    modport master (output out_valid, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_idx, output out_ready);
endinterface

// File: rtl/priority_encoder_q.sv
// priority_encoder_q
//   Collects sporadic, possibly multi-hot request strobes into a sticky pending
//   register and hands the indices downstream one at a time over a valid/ready
//   channel. Nothing is dropped: a request stays pending until its index is
//   loaded into the output stage. Arbitration is fixed priority (lowest index
//   first) or round-robin, selected per cycle by mode.
//   Parameters:
//     N   number of request lines, 2..256, need not be a power of two
//     W   index width, derived as $clog2(N) (local, not overridable)
//   Ports:
//     clk      clock, all state on the rising edge
//     rst      synchronous active-high reset
//     req_in   request strobes, one cycle high = one request
//     mode     0 = fixed priority, 1 = round-robin
//     down     output stage (out_valid / out_ready / out_idx), master side
//     pend     pending register contents
//     overrun  one-cycle pulse when a request merged into an already pending
//              one; exists only when PENC_OVERRUN_EN is defined
module priority_encoder_q #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_in,
    input  logic                 mode,
    priority_encoder_q_if.master down,
    output logic [N-1:0]         pend
`ifdef PENC_OVERRUN_EN
    ,
    output logic                 overrun
`endif
);
    localparam int W = $clog2(N);

    logic [N-1:0] pend_q;
    logic         valid_q;
    logic [W-1:0] idx_q;
    logic [W-1:0] ptr_q;

    logic         any;
    logic         stage_free;
    logic         load;
    logic [W-1:0] sel_fx;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel;
    logic [W-1:0] ptr_next;
    logic [N-1:0] clr_mask;
    logic         found;
    logic [W:0]   scan;

    assign any        = |pend_q;
    assign stage_free = !valid_q || down.out_ready;
    assign load       = stage_free && any;

    // Fixed priority: scanning downward leaves the lowest set index in sel_fx.
    always_comb begin
        sel_fx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_fx = W'(i);
            end
        end
    end

    // Round-robin: walk ptr, ptr+1, ... with an explicit wrap at N so that
    // non-power-of-two N never produces an index >= N.
    always_comb begin
        found  = 1'b0;
        sel_rr = '0;
        scan   = '0;
        for (int k = 0; k < N; k++) begin
            scan = {1'b0, ptr_q} + (W+1)'(k);
            if (scan >= (W+1)'(N)) begin
                scan = scan - (W+1)'(N);
            end
            if (!found && pend_q[scan[W-1:0]]) begin
                found  = 1'b1;
                sel_rr = scan[W-1:0];
            end
        end
    end

    assign sel      = mode ? sel_rr : sel_fx;
    assign ptr_next = (sel == W'(N - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        clr_mask = '0;
        if (load) begin
            clr_mask[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            // OR-ing req_in last makes a fresh request win over the clear of
            // the same bit in its load cycle.
            pend_q <= (pend_q & ~clr_mask) | req_in;
            if (stage_free) begin
                valid_q <= any;
                if (any) begin
                    idx_q <= sel;
                    ptr_q <= ptr_next;
                end
            end
        end
    end

`ifdef PENC_OVERRUN_EN
    logic overrun_q;

    // A bit being cleared this cycle and re-set is a new request, not a merge.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= |(req_in & pend_q & ~clr_mask);
        end
    end

    assign overrun = overrun_q;
`endif

    assign down.out_valid = valid_q;
    assign down.out_idx   = idx_q;
    assign pend           = pend_q;
endmodule

// File: tb/tb_priority_encoder_q.sv
// tb_priority_encoder_q
//   Directed, table-driven bench for priority_encoder_q with an N=8 and an
//   N=5 instance. Expected values are hand-computed per row.
module tb_priority_encoder_q;
    logic       clk;
    logic       rst;
    logic [7:0] req8;
    logic       mode8;
    logic [4:0] req5;
    logic       mode5;
    logic [7:0] pend8;
    logic [4:0] pend5;
`ifdef PENC_OVERRUN_EN
    logic       ovr8;
    logic       ovr5;
`endif

    int checks;
    int errors;

    priority_encoder_q_if #(.W(3)) bus8 ();
    priority_encoder_q_if #(.W(3)) bus5 ();

    priority_encoder_q #(.N(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .req_in (req8),
        .mode   (mode8),
        .down   (bus8),
        .pend   (pend8)
`ifdef PENC_OVERRUN_EN
        ,
        .overrun(ovr8)
`endif
    );

    priority_encoder_q #(.N(5)) dut5 (
        .clk    (clk),
        .rst    (rst),
        .req_in (req5),
        .mode   (mode5),
        .down   (bus5),
        .pend   (pend5)
`ifdef PENC_OVERRUN_EN
        ,
        .overrun(ovr5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       mode;
        logic       rdy;
        logic       v;
        logic [2:0] idx;
        logic [7:0] pend;
    } vec_t;

    vec_t tab8[38];
    vec_t tab5[7];

    function automatic vec_t mk(input logic [7:0] req, input logic mode, input logic rdy,
                                input logic v, input logic [2:0] idx, input logic [7:0] pend);
        vec_t t;
        t.req  = req;
        t.mode = mode;
        t.rdy  = rdy;
        t.v    = v;
        t.idx  = idx;
        t.pend = pend;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // N=8 stream: single, fixed multi-hot, round-robin vs fixed with held
        // requests, backpressure with accumulation, set-wins, mode change.
        tab8[0]  = mk(8'h20, 0, 1, 0, 0, 8'h20);
        tab8[1]  = mk(8'h00, 0, 1, 1, 5, 8'h00);
        tab8[2]  = mk(8'h00, 0, 1, 0, 0, 8'h00);
        tab8[3]  = mk(8'h91, 0, 1, 0, 0, 8'h91);
        tab8[4]  = mk(8'h00, 0, 1, 1, 0, 8'h90);
        tab8[5]  = mk(8'h00, 0, 1, 1, 4, 8'h80);
        tab8[6]  = mk(8'h00, 0, 1, 1, 7, 8'h00);
        tab8[7]  = mk(8'h00, 0, 1, 0, 0, 8'h00);
        tab8[8]  = mk(8'h81, 1, 1, 0, 0, 8'h81);
        tab8[9]  = mk(8'h81, 1, 1, 1, 0, 8'h81);
        tab8[10] = mk(8'h81, 1, 1, 1, 7, 8'h81);
        tab8[11] = mk(8'h81, 1, 1, 1, 0, 8'h81);
        tab8[12] = mk(8'h00, 1, 1, 1, 7, 8'h01);
        tab8[13] = mk(8'h00, 1, 1, 1, 0, 8'h00);
        tab8[14] = mk(8'h00, 1, 1, 0, 0, 8'h00);
        tab8[15] = mk(8'h81, 0, 1, 0, 0, 8'h81);
        tab8[16] = mk(8'h81, 0, 1, 1, 0, 8'h81);
        tab8[17] = mk(8'h81, 0, 1, 1, 0, 8'h81);
        tab8[18] = mk(8'h81, 0, 1, 1, 0, 8'h81);
        tab8[19] = mk(8'h00, 0, 1, 1, 0, 8'h80);
        tab8[20] = mk(8'h00, 0, 1, 1, 7, 8'h00);
        tab8[21] = mk(8'h00, 0, 1, 0, 0, 8'h00);
        tab8[22] = mk(8'h0C, 0, 0, 0, 0, 8'h0C);
        tab8[23] = mk(8'h00, 0, 0, 1, 2, 8'h08);
        tab8[24] = mk(8'h00, 0, 0, 1, 2, 8'h08);
        tab8[25] = mk(8'h40, 0, 0, 1, 2, 8'h48);
        tab8[26] = mk(8'h00, 0, 1, 1, 3, 8'h40);
        tab8[27] = mk(8'h00, 0, 1, 1, 6, 8'h00);
        tab8[28] = mk(8'h00, 0, 1, 0, 0, 8'h00);
        tab8[29] = mk(8'h02, 0, 1, 0, 0, 8'h02);
        tab8[30] = mk(8'h02, 0, 1, 1, 1, 8'h02);
        tab8[31] = mk(8'h00, 0, 1, 1, 1, 8'h00);
        tab8[32] = mk(8'h00, 0, 1, 0, 0, 8'h00);
        tab8[33] = mk(8'h15, 1, 1, 0, 0, 8'h15);
        tab8[34] = mk(8'h00, 1, 1, 1, 2, 8'h11);
        tab8[35] = mk(8'h00, 0, 1, 1, 0, 8'h10);
        tab8[36] = mk(8'h00, 0, 1, 1, 4, 8'h00);
        tab8[37] = mk(8'h00, 0, 1, 0, 0, 8'h00);

        // N=5 round-robin with lines 0 and 4: pointer must wrap 4 -> 0.
        tab5[0] = mk(8'h11, 1, 1, 0, 0, 8'h11);
        tab5[1] = mk(8'h11, 1, 1, 1, 0, 8'h11);
        tab5[2] = mk(8'h11, 1, 1, 1, 4, 8'h11);
        tab5[3] = mk(8'h11, 1, 1, 1, 0, 8'h11);
        tab5[4] = mk(8'h00, 1, 1, 1, 4, 8'h01);
        tab5[5] = mk(8'h00, 1, 1, 1, 0, 8'h00);
        tab5[6] = mk(8'h00, 1, 1, 0, 0, 8'h00);

        rst            = 1'b1;
        req8           = 8'hFF;
        mode8          = 1'b0;
        req5           = 5'h1F;
        mode5          = 1'b0;
        bus8.out_ready = 1'b1;
        bus5.out_ready = 1'b1;
        tick();
        tick();
        check("n8 reset pend", 32'(pend8), 32'h0);
        check("n8 reset valid", 32'(bus8.out_valid), 32'h0);
        check("n8 reset idx", 32'(bus8.out_idx), 32'h0);
        check("n5 reset pend", 32'(pend5), 32'h0);
        check("n5 reset valid", 32'(bus5.out_valid), 32'h0);
`ifdef PENC_OVERRUN_EN
        check("n8 reset overrun", 32'(ovr8), 32'h0);
`endif
        rst  = 1'b0;
        req8 = 8'h00;
        req5 = 5'h00;

        for (int r = 0; r < 38; r++) begin
            req8           = tab8[r].req;
            mode8          = tab8[r].mode;
            bus8.out_ready = tab8[r].rdy;
            tick();
            check($sformatf("n8 row%0d valid", r + 1), 32'(bus8.out_valid), 32'(tab8[r].v));
            if (tab8[r].v) begin
                check($sformatf("n8 row%0d idx", r + 1), 32'(bus8.out_idx), 32'(tab8[r].idx));
            end
            check($sformatf("n8 row%0d pend", r + 1), 32'(pend8), 32'(tab8[r].pend));
        end

        // Reset in the middle of operation drops pending work and the held index.
        req8           = 8'hFF;
        mode8          = 1'b0;
        bus8.out_ready = 1'b0;
        tick();
        req8 = 8'h00;
        tick();
        check("n8 pre-reset valid", 32'(bus8.out_valid), 32'h1);
        check("n8 pre-reset pend", 32'(pend8), 32'hFE);
        rst  = 1'b1;
        req8 = 8'hFF;
        tick();
        check("n8 midrst pend", 32'(pend8), 32'h0);
        check("n8 midrst valid", 32'(bus8.out_valid), 32'h0);
        check("n8 midrst idx", 32'(bus8.out_idx), 32'h0);
        rst  = 1'b0;
        req8 = 8'h00;
        tick();
        check("n8 postrst pend", 32'(pend8), 32'h0);
        check("n8 postrst valid", 32'(bus8.out_valid), 32'h0);

        // Round-robin pointer restarts at 0 after reset.
        req8           = 8'h81;
        mode8          = 1'b1;
        bus8.out_ready = 1'b1;
        tick();
        req8 = 8'h00;
        tick();
        check("n8 rr after reset idx", 32'(bus8.out_idx), 32'h0);
        check("n8 rr after reset valid", 32'(bus8.out_valid), 32'h1);
        tick();
        check("n8 rr after reset idx2", 32'(bus8.out_idx), 32'h7);

        for (int r = 0; r < 7; r++) begin
            req5           = tab5[r].req[4:0];
            mode5          = tab5[r].mode;
            bus5.out_ready = tab5[r].rdy;
            tick();
            check($sformatf("n5 row%0d valid", r + 1), 32'(bus5.out_valid), 32'(tab5[r].v));
            if (bus5.out_valid) begin
                check($sformatf("n5 row%0d idx range", r + 1), 32'(bus5.out_idx < 3'd5), 32'h1);
            end
            if (tab5[r].v) begin
                check($sformatf("n5 row%0d idx", r + 1), 32'(bus5.out_idx), 32'(tab5[r].idx));
            end
            check($sformatf("n5 row%0d pend", r + 1), 32'(pend5), 32'(tab5[r].pend));
        end

`ifdef PENC_OVERRUN_EN
        mode5          = 1'b0;
        bus5.out_ready = 1'b0;
        req5           = 5'h01;
        tick();
        check("n5 ovr a", 32'(ovr5), 32'h0);
        req5 = 5'h08;
        tick();
        check("n5 ovr b", 32'(ovr5), 32'h0);
        check("n5 ovr b pend", 32'(pend5), 32'h08);
        req5 = 5'h00;
        tick();
        check("n5 ovr c", 32'(ovr5), 32'h0);
        req5 = 5'h08;
        tick();
        check("n5 ovr merge", 32'(ovr5), 32'h1);
        req5 = 5'h00;
        tick();
        check("n5 ovr pulse end", 32'(ovr5), 32'h0);
        // Re-set of the bit being loaded this cycle is a new request, not a merge.
        bus5.out_ready = 1'b1;
        req5           = 5'h08;
        tick();
        check("n5 ovr set-on-clear", 32'(ovr5), 32'h0);
        check("n5 ovr set-on-clear pend", 32'(pend5), 32'h08);
        req5 = 5'h00;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
